// File: rtl/gfp8_pkg.sv
// rtl/gfp8_pkg.sv - shared GFP8/FP16 constants, state type and exponent helpers
package gfp8_pkg;

    localparam int GFP_MANT_W   = 8;
    localparam int GFP_EXP_W    = 8;
    localparam int GFP_MANT_MAX = 127;
    localparam int GFP_ALIGN    = 6;

    localparam int FP16_BIAS     = 15;
    localparam int FP16_EMIN     = -14;
    localparam int FP16_SIGN_BIT = 15;
    localparam int FP16_EXP_MSB  = 14;
    localparam int FP16_EXP_LSB  = 10;
    localparam int FP16_FRAC_MSB = 9;
    localparam int FP16_FRAC_LSB = 0;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } gfp8_state_e;

    // Exponent field all ones: Inf or NaN.
    function automatic logic fp16_is_special(input logic [15:0] x);
        return &x[FP16_EXP_MSB:FP16_EXP_LSB];
    endfunction

    // Unbiased exponent of a finite element; denormals and zero share EMIN.
    function automatic logic signed [GFP_EXP_W-1:0] fp16_exp(input logic [15:0] x);
        logic [4:0] ef;
        ef = x[FP16_EXP_MSB:FP16_EXP_LSB];
        if (ef == 5'd0)
            return GFP_EXP_W'(FP16_EMIN);
        else
            return {3'b000, ef} - GFP_EXP_W'(FP16_BIAS);
    endfunction

endpackage

// File: rtl/fp16_to_gfp8_if.sv
// rtl/fp16_to_gfp8_if.sv - FP16 input stream and GFP8 output stream bundle
// Ports (slave = quantizer side):
//   i_fp16/i_valid -> o_ready       FP16 element stream into the block
//   o_mant/o_exp/o_last/o_special/o_valid -> i_ready   GFP8 stream out
interface fp16_to_gfp8_if;
    import gfp8_pkg::*;

    logic [15:0]                  i_fp16;
    logic                         i_valid;
    logic                         o_ready;
    logic signed [GFP_MANT_W-1:0] o_mant;
    logic signed [GFP_EXP_W-1:0]  o_exp;
    logic                         o_valid;
    logic                         i_ready;
    logic                         o_last;
    logic                         o_special;

    modport master (
        output i_fp16, i_valid, i_ready,
        input  o_ready, o_mant, o_exp, o_valid, o_last, o_special
    );

    modport slave (
        input  i_fp16, i_valid, i_ready,
        output o_ready, o_mant, o_exp, o_valid, o_last, o_special
    );
endinterface

// File: rtl/fp16_gfp8_quant.sv
// rtl/fp16_gfp8_quant.sv - combinational align, round-to-nearest-even and saturate of one element
// Ports:
//   fp16   in   FP16 element
//   e_max  in   group maximum unbiased exponent E
//   mant   out  signed GFP8 mantissa, -127..127
module fp16_gfp8_quant
    import gfp8_pkg::*;
(
    input  logic [15:0]                  fp16,
    input  logic signed [GFP_EXP_W-1:0]  e_max,
    output logic signed [GFP_MANT_W-1:0] mant
);

    logic                         sign;
    logic                         special;
    logic [10:0]                  sig;
    logic signed [GFP_EXP_W-1:0]  e_i;
    logic signed [8:0]            sh_full;
    logic [3:0]                   sh;
    logic [25:0]                  aligned;
    logic [10:0]                  int_part;
    logic                         guard;
    logic                         sticky;
    logic [11:0]                  rounded;
    logic [6:0]                   mag;
    logic [GFP_MANT_W-1:0]        mag8;

    always_comb begin
        sign    = fp16[FP16_SIGN_BIT];
        special = fp16_is_special(fp16);
        sig     = {|fp16[FP16_EXP_MSB:FP16_EXP_LSB], fp16[FP16_FRAC_MSB:FP16_FRAC_LSB]};
        e_i     = fp16_exp(fp16);

        // Shift puts the group's largest element in the 64..127 band.
        sh_full = 9'sd4 + {e_max[GFP_EXP_W-1], e_max} - {e_i[GFP_EXP_W-1], e_i};
        if (sh_full > 9'sd15)
            sh = 4'd15;
        else if (sh_full < 9'sd0)
            sh = 4'd0;
        else
            sh = sh_full[3:0];

        // 15 fraction bits below the binary point hold guard and sticky for any sh <= 15.
        aligned  = {sig, 15'd0} >> sh;
        int_part = aligned[25:15];
        guard    = aligned[14];
        sticky   = |aligned[13:0];
        rounded  = {1'b0, int_part} + {11'd0, guard & (sticky | int_part[0])};

        if (special || rounded > 12'(GFP_MANT_MAX))
            mag = 7'(GFP_MANT_MAX);
        else
            mag = rounded[6:0];

        mag8 = {1'b0, mag};
        mant = sign ? (~mag8 + 8'd1) : mag8;
    end

endmodule

// File: rtl/fp16_to_gfp8.sv
// rtl/fp16_to_gfp8.sv - FP16 stream to block-floating-point GFP8 group quantizer
// Ports:
//   i_clk      in   clock
//   i_reset_n  in   asynchronous active-low reset
//   bus        slave modport: FP16 input stream, GFP8 output stream with
//              shared exponent o_exp, group end o_last and Inf/NaN flag o_special
module fp16_to_gfp8
    import gfp8_pkg::*;
#(
    parameter int GROUP_SIZE = 32
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    fp16_to_gfp8_if.slave  bus
);

    localparam int             IDX_W    = $clog2(GROUP_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_SIZE - 1);

    gfp8_state_e                  state;
    logic [15:0]                  grp_buf [GROUP_SIZE];
    logic [IDX_W-1:0]             wr_idx;
    logic [IDX_W-1:0]             rd_idx;
    logic signed [GFP_EXP_W-1:0]  e_run;
    logic                         flag_run;

    logic                         in_fire;
    logic                         in_special;
    logic signed [GFP_EXP_W-1:0]  e_in;
    logic signed [GFP_EXP_W-1:0]  e_next;
    logic                         flag_next;
    logic signed [GFP_EXP_W-1:0]  e_grp;
    logic                         advance;
    logic signed [GFP_MANT_W-1:0] q_mant;

    assign bus.o_ready = (state == ST_COLLECT);

    always_comb begin
        in_fire    = bus.i_valid && (state == ST_COLLECT);
        in_special = fp16_is_special(bus.i_fp16);
        e_in       = fp16_exp(bus.i_fp16);
        e_next     = (!in_special && (e_in > e_run)) ? e_in : e_run;
        flag_next  = flag_run | in_special;
        // o_exp is held for the whole emit phase, so E is recovered from it.
        e_grp      = bus.o_exp + GFP_EXP_W'(GFP_ALIGN);
        advance    = !bus.o_valid || bus.i_ready;
    end

    fp16_gfp8_quant u_quant (
        .fp16  (grp_buf[rd_idx]),
        .e_max (e_grp),
        .mant  (q_mant)
    );

    // Group storage needs no reset: it is always fully rewritten before being read.
    always_ff @(posedge i_clk) begin
        if (in_fire)
            grp_buf[wr_idx] <= bus.i_fp16;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= ST_COLLECT;
            wr_idx        <= '0;
            rd_idx        <= '0;
            e_run         <= GFP_EXP_W'(FP16_EMIN);
            flag_run      <= 1'b0;
            bus.o_mant    <= '0;
            bus.o_exp     <= '0;
            bus.o_valid   <= 1'b0;
            bus.o_last    <= 1'b0;
            bus.o_special <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (in_fire) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (wr_idx == LAST_IDX) begin
                            bus.o_exp     <= e_next - GFP_EXP_W'(GFP_ALIGN);
                            bus.o_special <= flag_next;
                            e_run         <= GFP_EXP_W'(FP16_EMIN);
                            flag_run      <= 1'b0;
                            rd_idx        <= '0;
                            state         <= ST_EMIT;
                        end else begin
                            e_run    <= e_next;
                            flag_run <= flag_next;
                        end
                    end
                end
                ST_EMIT: begin
                    if (advance) begin
                        if (bus.o_valid && bus.o_last) begin
                            // Final handshake of the group: buffer is free again.
                            bus.o_valid   <= 1'b0;
                            bus.o_last    <= 1'b0;
                            bus.o_special <= 1'b0;
                            state         <= ST_COLLECT;
                        end else begin
                            bus.o_mant  <= q_mant;
                            bus.o_last  <= (rd_idx == LAST_IDX);
                            bus.o_valid <= 1'b1;
                            rd_idx      <= rd_idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: doc/fp16_to_gfp8.md
# fp16_to_gfp8

Block-floating-point quantizer: accepts a stream of IEEE 754 FP16 values, buffers one group of GROUP_SIZE elements, and finds the group's maximum exponent. It then emits the group as signed 8-bit GFP8 mantissas sharing one unbiased signed 8-bit exponent, so that value = mant × 2^exp. It is the inverse path of the GFP8→FP16 result converter: it feeds FP16 activations and weights back into GFP8 storage for the dot-product engines.

## Interface
- GROUP_SIZE, 32: elements per group; power of two, 4..64.
- i_clk  in  1  clock.
- i_reset_n  in  1  reset; asynchronous, active-low.
- i_fp16  in  16  FP16 input element.
- i_valid  in  1  i_fp16 valid.
- o_ready  out  1  block accepts input; high only in COLLECT.
- o_mant  out  8  signed two's-complement mantissa, range −127..127.
- o_exp  out  8  signed unbiased shared exponent; constant for the whole group.
- o_valid  out  1  o_mant/o_exp/o_last valid.
- i_ready  in  1  downstream accepts output.
- o_last  out  1  marks the final element of the group.
- o_special  out  1  the group contained Inf/NaN; valid with every element of the group.

## Operation
- States: COLLECT and EMIT. Reset enters COLLECT.
- **COLLECT**
  - On each i_valid && o_ready edge: buf[wr_idx] ← i_fp16, and wr_idx increments.
  - Per element, compute e_i:
    - Normal: e_i = exp_field − 15.
    - Denormal or zero: e_i = −14.
    - Inf/NaN: excluded from the max; sets the special flag.
  - E = running max of e_i; it starts at −14 for each new group.
  - On accepting element GROUP_SIZE−1: o_exp ← E − 6, o_special ← flag, go to EMIT, reset rd_idx.
- **EMIT**
  - The output register advances when !o_valid || i_ready. On advance it loads quant(buf[rd_idx]) and rd_idx increments.
  - o_last = (loaded index == GROUP_SIZE−1).
  - After the o_valid && i_ready && o_last handshake: o_valid drops (unless the next group is already loading — not possible, since single buffer), the special flag clears, and the state returns to COLLECT.
- **quant(x)**
  - Significand s: 11 bits; hidden bit = 1 for normals, 0 for denormals and zero.
  - Shift sh = 4 + E − e_i, 4..33. When sh > 15, treat as 15; the result then rounds to 0.
  - Magnitude = s >> sh, rounded to nearest with ties to even. Guard bit is the first dropped bit; sticky is the OR of the rest.
  - Saturate the magnitude at 127.
  - Apply the FP16 sign: two's-complement negate if sign = 1. −0 gives 0.
  - Inf/NaN: ±127, using the sign bit.
- Largest finite element maps to magnitude 64..127.
- All-zero group: E = −14, o_exp = −20, all mantissas 0.

## Timing
- Reset values:
  - o_mant = 0, o_exp = 0, o_valid = 0, o_last = 0, o_special = 0.
  - o_ready = 1; state COLLECT; wr_idx = rd_idx = 0.
- Latency: last input accepted at edge k → EMIT from k → element 0 on the outputs after edge k+1.
- With i_ready held high: one element per cycle, GROUP_SIZE cycles.
- Group period: 2·GROUP_SIZE + 1 cycles, with no overlap between collect and emit.
- Backpressure: while o_valid && !i_ready, o_mant, o_last, o_exp and o_special hold stable.
- o_ready stays 0 from the acceptance edge of the last element until the last output handshake completes.
- i_valid while o_ready = 0 is ignored; upstream must hold its data.
- Reset mid-operation: the partial group is discarded and all outputs return to their reset values immediately.
- o_exp updates only on the COLLECT→EMIT edge.

## Structure
- Package gfp8_pkg holds:
  - GFP_MANT_W = 8, GFP_EXP_W = 8, GFP_MANT_MAX = 127, GFP_ALIGN = 6.
  - FP16_BIAS = 15, FP16_EMIN = −14.
  - FP16 field positions.
  - State enum typedef.
- Sub-module fp16_gfp8_quant: combinational align, RNE and saturate for one element, with inputs fp16 and E and output mant.
- Top-level contents: buffer (GROUP_SIZE×16 flops), indices, max tracker, FSM and output register.

## Test plan
- All 32 elements 0x3C00 (1.0) → o_exp = −6; every o_mant = 64; o_last on element 31 only; o_special = 0.
- Element 0 = 0x4000, element 1 = 0xBC00, rest 0x0000 → o_exp = −5; mantissas 64, −32, then 0s.
- Max element 0x3C00, others 0x3C08 and 0x3C18 → 64 (tie to even) and 66 (tie up to even). Second group with max 0x4BFF → o_exp = −3 and mantissa saturates at 127.
- Group of 0x3C00 plus one 0x7C00 and one 0xFE00 → o_exp = −6; mantissas 127 and −127; o_special = 1 throughout. The next clean group has o_special = 0.
- i_ready low for 5 cycles at element 10 → outputs frozen, no loss or duplication, o_ready = 0 until the last handshake.
- Assert reset after 10 inputs → reset values immediately; the next full group of 0x3C00 yields the result of the first test.
